// File: rtl/attn_pkg.sv
// Shared types and constants for the query/key score scheduler.
// Holds the FSM state enum, accumulator width, default geometry and the 8-bit saturation helper.
package attn_pkg;

  typedef enum logic [0:0] {
    ST_LOAD_Q   = 1'b0,
    ST_STREAM_K = 1'b1
  } state_e;

  localparam int ACC_W      = 18;
  localparam int N_DEF      = 4;
  localparam int ROWS_DEF   = 4;
  localparam int SHIFT_DEF  = 4;

  // Clamp a shifted accumulator value into an unsigned byte.
  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] v);
    if (v > 18'd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/qk_mac.sv
// Multiply-accumulate of two unsigned bytes into an ACC_W-bit register.
// clear loads the product instead of adding it, starting a new dot product.
module qk_mac
  import attn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             clear,
  input  logic             en,
  output logic [ACC_W-1:0] acc
);

  logic [15:0]      product_s;
  logic [ACC_W-1:0] acc_r;

  assign product_s = 16'(a) * 16'(b);
  assign acc       = acc_r;

  // Accumulator register: load on the first element of a row, add afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      if (clear) begin
        acc_r <= ACC_W'(product_s);
      end else begin
        acc_r <= acc_r + ACC_W'(product_s);
      end
    end
  end

endmodule

// File: rtl/score_scheduler.sv
// Loads an N-byte query, then scores ROWS key rows against it, emitting one
// saturated, shifted dot product per row through a valid/ready output stage.
module score_scheduler
  import attn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_vld,
  output logic       in_rdy,
  output logic [7:0] out_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       busy
);

  localparam int QW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e           state_r;
  logic [7:0]       q_r [N];
  logic [QW-1:0]    q_idx_r;
  logic [QW-1:0]    k_idx_r;
  logic [RW-1:0]    row_idx_r;
  logic [7:0]       out_data_r;
  logic             out_vld_r;
  logic             out_last_r;

  logic             in_rdy_s;
  logic             busy_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             k_last_s;
  logic             row_last_s;
  logic             mac_en_s;
  logic             mac_clear_s;
  logic             capture_s;
  logic [15:0]      product_s;
  logic [ACC_W-1:0] mac_acc_s;
  logic [ACC_W-1:0] row_sum_s;
  logic [7:0]       score_s;

  assign k_last_s    = (k_idx_r == QW'(N - 1));
  assign row_last_s  = (row_idx_r == RW'(ROWS - 1));
  assign in_xfer_s   = in_vld && in_rdy_s;
  assign out_xfer_s  = out_vld_r && out_rdy;
  assign mac_en_s    = in_xfer_s && (state_r == ST_STREAM_K);
  assign mac_clear_s = (k_idx_r == {QW{1'b0}});
  assign capture_s   = mac_en_s && k_last_s;

  // The row total is formed alongside the MAC so the score is ready on the last key byte.
  assign product_s = 16'(q_r[k_idx_r]) * 16'(in_data);
  assign row_sum_s = (mac_clear_s ? {ACC_W{1'b0}} : mac_acc_s) + ACC_W'(product_s);
  assign score_s   = sat8(row_sum_s >> SHIFT);

  // Handshake and status decode; in_rdy depends on registered state only.
  always_comb begin
    in_rdy_s = 1'b0;
    busy_s   = 1'b1;
    case (state_r)
      ST_LOAD_Q: begin
        in_rdy_s = 1'b1;
        if (q_idx_r == {QW{1'b0}}) begin
          busy_s = 1'b0;
        end else begin
          busy_s = 1'b1;
        end
      end
      ST_STREAM_K: begin
        in_rdy_s = !(out_vld_r && k_last_s);
        busy_s   = 1'b1;
      end
      default: begin
        in_rdy_s = 1'b0;
        busy_s   = 1'b1;
      end
    endcase
  end

  qk_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (q_r[k_idx_r]),
    .b     (in_data),
    .clear (mac_clear_s),
    .en    (mac_en_s),
    .acc   (mac_acc_s)
  );

  // Query storage; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD_Q) && in_xfer_s) begin
      q_r[q_idx_r] <= in_data;
    end
  end

  // Scheduler FSM, index counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_LOAD_Q;
      q_idx_r    <= {QW{1'b0}};
      k_idx_r    <= {QW{1'b0}};
      row_idx_r  <= {RW{1'b0}};
      out_data_r <= 8'd0;
      out_vld_r  <= 1'b0;
      out_last_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD_Q: begin
          if (in_xfer_s) begin
            if (q_idx_r == QW'(N - 1)) begin
              q_idx_r <= {QW{1'b0}};
              state_r <= ST_STREAM_K;
            end else begin
              q_idx_r <= q_idx_r + QW'(1);
            end
          end
        end
        ST_STREAM_K: begin
          if (in_xfer_s) begin
            if (k_last_s) begin
              k_idx_r <= {QW{1'b0}};
              if (row_last_s) begin
                row_idx_r <= {RW{1'b0}};
                state_r   <= ST_LOAD_Q;
              end else begin
                row_idx_r <= row_idx_r + RW'(1);
              end
            end else begin
              k_idx_r <= k_idx_r + QW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_LOAD_Q;
        end
      endcase

      // A capture cannot coincide with a held output because in_rdy blocks it.
      if (capture_s) begin
        out_data_r <= score_s;
        out_vld_r  <= 1'b1;
        out_last_r <= row_last_s;
      end else if (out_xfer_s) begin
        out_vld_r  <= 1'b0;
        out_last_r <= 1'b0;
      end
    end
  end

  assign in_rdy   = in_rdy_s;
  assign busy     = busy_s;
  assign out_data = out_data_r;
  assign out_vld  = out_vld_r;
  assign out_last = out_last_r;

endmodule

// File: tb/tb_score_scheduler.sv
// Scoreboard bench for score_scheduler: a byte-stream reference model queues
// expected scores, and an independent monitor checks every output transfer.
module tb_score_scheduler;

  localparam int N     = 4;
  localparam int ROWS  = 4;
  localparam int SHIFT = 4;
  localparam int QLEN  = N + ROWS * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       expq[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         byte_cnt = 0;
  int         q_m[N];
  int         acc_m = 0;
  int         lat_due = -1;
  int         lat_val = 0;
  int         rdy_mode = 0;
  int         gap_max = 0;

  score_scheduler #(.N(N), .ROWS(ROWS), .SHIFT(SHIFT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: the stream is N query bytes, then ROWS rows of N key bytes.
  task automatic model_accept(input int d);
    int k;
    int r;
    int s;
    if (byte_cnt < N) begin
      q_m[byte_cnt] = d;
    end else begin
      k = (byte_cnt - N) % N;
      r = (byte_cnt - N) / N;
      if (k == 0) acc_m = 0;
      acc_m += q_m[k] * d;
      if (k == N - 1) begin
        s = acc_m >> SHIFT;
        if (s > 255) s = 255;
        expq.push_back({8'(s), (r == ROWS - 1)});
        lat_due = cyc + 1;
        lat_val = s;
      end
    end
    byte_cnt = (byte_cnt + 1) % QLEN;
  endtask

  function automatic logic [7:0] rb();
    if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 255));
    else return 8'($urandom_range(0, 31));
  endfunction

  // Offer one byte (after an optional idle gap) until accepted or timed out.
  task automatic send(input logic [7:0] d);
    bit acc_ok;
    acc_ok = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      in_vld = 1'b0;
      @(posedge clk); #1;
    end
    in_vld  = 1'b1;
    in_data = d;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (in_rdy) begin
        model_accept(int'(d));
        acc_ok = 1'b1;
      end
      @(posedge clk); #1;
      if (acc_ok) break;
    end
    in_vld = 1'b0;
    if (!acc_ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_bytes(input int count);
    for (int i = 0; i < count; i++) send(rb());
  endtask

  task automatic drain();
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_vld) break;
    end
    check("drain_empty", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    in_vld = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    byte_cnt = 0;
    expq.delete();
    lat_due  = -1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_out_vld"}, out_vld, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_in_rdy"}, in_rdy, 1);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
  endtask

  // out_rdy policy: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output transfer, checks hold and latency.
  initial begin
    bit         hold;
    logic [7:0] hd;
    logic       hl;
    exp_t       e;
    hold = 1'b0;
    hd   = 8'd0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_vld", out_vld, 1);
          check("hold_data", out_data, hd);
          check("hold_last", out_last, hl);
        end
        if (cyc == lat_due) begin
          check("latency_vld", out_vld, 1);
          check("latency_data", out_data, lat_val);
        end
        if (out_vld && out_rdy) begin
          if (expq.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = expq.pop_front();
            check("score", out_data, e.d);
            check("last", out_last, e.l);
          end
        end
        hold = out_vld && !out_rdy;
        hd   = out_data;
        hl   = out_last;
      end
    end
  end

  initial begin
    logic [7:0] held_byte;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_idle("reset");

    // q=1,2,3,4 against four rows of 16s: every score is 160>>4 = 10.
    for (int i = 1; i <= N; i++) send(8'(i));
    for (int i = 0; i < ROWS * N; i++) send(8'd16);
    @(negedge clk);
    check("back_to_load_busy", busy, 0);
    @(posedge clk); #1;

    // All-255 operands saturate.
    for (int i = 0; i < QLEN; i++) send(8'd255);
    drain();

    // Output stalled after row 0: row 1 stops at its last key byte.
    rdy_mode = 2;
    send_bytes(N + N + (N - 1));
    held_byte = rb();
    in_vld    = 1'b1;
    in_data   = held_byte;
    repeat (10) begin
      @(negedge clk);
      check("stall_in_rdy", in_rdy, 0);
      @(posedge clk); #1;
    end
    in_vld   = 1'b0;
    rdy_mode = 0;
    send(held_byte);
    send_bytes((ROWS - 2) * N);
    drain();

    // Reset in the middle of row 2 discards everything.
    send_bytes(N + 2 * N + 2);
    do_reset();
    check_idle("midreset");
    send_bytes(QLEN);
    drain();

    // Random input gaps with an always-ready sink.
    gap_max = 3;
    send_bytes(3 * QLEN);
    gap_max = 0;
    drain();

    // Next query loads while the last score is held.
    send_bytes(QLEN - 1);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    send(rb());
    send_bytes(N);
    @(negedge clk);
    check("held_last_vld", out_vld, 1);
    check("held_last_flag", out_last, 1);
    check("next_query_busy", busy, 1);
    @(posedge clk); #1;
    rdy_mode = 0;
    send_bytes(ROWS * N);
    drain();

    // Fully random handshakes on both sides.
    rdy_mode = 1;
    gap_max  = 2;
    send_bytes(4 * QLEN);
    rdy_mode = 0;
    gap_max  = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
